// File: rtl/cnn_pool_kxk.sv
// rtl/cnn_pool_kxk.sv - KxK average/max pooling engine over a channel-interleaved raster stream
//
// Optional feature macro: CNN_POOL_RELU_EN (fused ReLU on the final result).
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   valid_in   pxl_in carries a beat this cycle
//   pxl_in     signed input beat (channel 0 first within each pixel)
//   mode       0 = average, 1 = max; latched at the first beat of a frame
//   stride2    0 = stride 1, 1 = stride 2; latched at the first beat of a frame
//   pxl_out    signed pooled result, holds when valid_out = 0
//   valid_out  pxl_out valid
//   frame_done one-cycle pulse, 3 cycles after the last beat of a frame
module cnn_pool_kxk #(
    parameter int DATA_WIDTH     = 16,
    parameter int IMAGE_WIDTH    = 16,
    parameter int IMAGE_HEIGHT   = 16,
    parameter int CHANNEL_NUM_IN = 512,
    parameter int KERNEL         = 3,
    parameter int RECIP          = (65536 + KERNEL * KERNEL - 1) / (KERNEL * KERNEL)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  mode,
    input  logic                  stride2,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);
    localparam int KK    = KERNEL * KERNEL;
    localparam int SW    = DATA_WIDTH + $clog2(KK);
    localparam int CHW   = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
    localparam int COLW  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROWW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int DEPTH = CHANNEL_NUM_IN * IMAGE_WIDTH;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = SW + 17;
    localparam logic signed [SW+1:0] SAT_MAX = (SW + 2)'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW+1:0] SAT_MIN = ~SAT_MAX;

    // Raster position of the beat currently on pxl_in
    logic [CHW-1:0]  r_ch;
    logic [COLW-1:0] r_col;
    logic [ROWW-1:0] r_row;
    logic            r_mode;
    logic            r_stride;

    // Line buffer: entry i holds row (row-(K-1)+i) for every (col, ch)
    logic signed [DATA_WIDTH-1:0] r_lb   [KERNEL-1][DEPTH];
    // Per-channel history of the previous K-1 column vectors; [0] is col-1
    logic signed [DATA_WIDTH-1:0] r_hist [CHANNEL_NUM_IN][KERNEL-1][KERNEL];

    logic                         w_first;
    logic                         w_last;
    logic                         w_qual;
    logic [AW-1:0]                w_addr;
    logic signed [DATA_WIDTH-1:0] w_colv [KERNEL];
    logic signed [DATA_WIDTH-1:0] w_win  [KERNEL][KERNEL];

    // Pipeline stage registers
    logic signed [DATA_WIDTH-1:0] r_s1_win [KERNEL][KERNEL];
    logic                         r_s1_vld, r_s1_mode, r_s1_last;
    logic signed [SW-1:0]         r_s2_sum;
    logic signed [DATA_WIDTH-1:0] r_s2_max;
    logic                         r_s2_vld, r_s2_mode, r_s2_last;

    logic signed [SW-1:0]         w_sum;
    logic signed [DATA_WIDTH-1:0] w_max;
    logic [SW-1:0]                w_abs;
    logic [PW-1:0]                w_prod;
    logic [SW:0]                  w_mag;
    logic signed [SW+1:0]         w_res;
    logic signed [DATA_WIDTH-1:0] w_avg;
    logic signed [DATA_WIDTH-1:0] w_final;

    assign w_first = (r_ch == '0) && (r_col == '0) && (r_row == '0);
    assign w_last  = (r_ch == CHW'(CHANNEL_NUM_IN - 1)) && (r_col == COLW'(IMAGE_WIDTH - 1))
                  && (r_row == ROWW'(IMAGE_HEIGHT - 1));
    assign w_addr  = AW'(int'(r_col) * CHANNEL_NUM_IN + int'(r_ch));

    // Row/col gating is what keeps stale line-buffer data out of any window
    always_comb begin
        w_qual = (int'(r_row) >= KERNEL - 1) && (int'(r_col) >= KERNEL - 1);
        if (r_stride) begin
            w_qual = w_qual && (((int'(r_row) - KERNEL + 1) & 1) == 0)
                            && (((int'(r_col) - KERNEL + 1) & 1) == 0);
        end
    end

    always_comb begin
        for (int i = 0; i < KERNEL - 1; i++) begin
            w_colv[i] = r_lb[i][w_addr];
        end
        w_colv[KERNEL-1] = $signed(pxl_in);
        for (int i = 0; i < KERNEL; i++) begin
            w_win[KERNEL-1][i] = w_colv[i];
            for (int j = 0; j < KERNEL - 1; j++) begin
                w_win[KERNEL-2-j][i] = r_hist[r_ch][j][i];
            end
        end
    end

    // Counters and frame-level settings
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch     <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_mode   <= 1'b0;
            r_stride <= 1'b0;
        end else if (valid_in) begin
            if (w_first) begin
                r_mode   <= mode;
                r_stride <= stride2;
            end
            if (r_ch == CHW'(CHANNEL_NUM_IN - 1)) begin
                r_ch <= '0;
                if (r_col == COLW'(IMAGE_WIDTH - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == ROWW'(IMAGE_HEIGHT - 1)) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else begin
                r_ch <= r_ch + 1'b1;
            end
        end
    end

    // Line buffer and column history are data-only storage, never reset
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int i = 0; i < KERNEL - 2; i++) begin
                r_lb[i][w_addr] <= r_lb[i+1][w_addr];
            end
            r_lb[KERNEL-2][w_addr] <= $signed(pxl_in);
            for (int i = 0; i < KERNEL; i++) begin
                r_hist[r_ch][0][i] <= w_colv[i];
                for (int j = 1; j < KERNEL - 1; j++) begin
                    r_hist[r_ch][j][i] <= r_hist[r_ch][j-1][i];
                end
            end
        end
    end

    // Stage 1: capture window
    always_ff @(posedge clk) begin
        if (valid_in && w_qual) begin
            r_s1_win <= w_win;
        end
    end

    // Stage 2: full-precision sum and signed max
    always_comb begin
        w_sum = '0;
        w_max = r_s1_win[0][0];
        for (int j = 0; j < KERNEL; j++) begin
            for (int i = 0; i < KERNEL; i++) begin
                w_sum = w_sum + SW'(r_s1_win[j][i]);
                if (r_s1_win[j][i] > w_max) begin
                    w_max = r_s1_win[j][i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_s1_vld) begin
            r_s2_sum  <= w_sum;
            r_s2_max  <= w_max;
            r_s2_mode <= r_s1_mode;
        end
    end

    // Stage 3: sign-magnitude reciprocal scaling so negative averages truncate toward zero
    always_comb begin
        w_abs  = r_s2_sum[SW-1] ? (~r_s2_sum + SW'(1)) : r_s2_sum;
        w_prod = PW'(w_abs) * PW'(RECIP);
        w_mag  = (SW + 1)'(w_prod >> 16);
        w_res  = r_s2_sum[SW-1] ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
        if (w_res > SAT_MAX) begin
            w_avg = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_res < SAT_MIN) begin
            w_avg = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            w_avg = w_res[DATA_WIDTH-1:0];
        end
        w_final = r_s2_mode ? r_s2_max : w_avg;
`ifdef CNN_POOL_RELU_EN
        if (w_final[DATA_WIDTH-1]) begin
            w_final = '0;
        end
`endif
    end

    // Valid/done pipeline and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_vld   <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s2_last  <= 1'b0;
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_s1_vld   <= valid_in && w_qual;
            r_s1_mode  <= r_mode;
            r_s1_last  <= valid_in && w_last;
            r_s2_vld   <= r_s1_vld;
            r_s2_last  <= r_s1_last;
            valid_out  <= r_s2_vld;
            frame_done <= r_s2_last;
            if (r_s2_vld) begin
                pxl_out <= w_final;
            end
        end
    end
endmodule

// File: tb/tb_cnn_pool_kxk.sv
// tb/tb_cnn_pool_kxk.sv - directed table-driven bench for cnn_pool_kxk (W=H=4, C=2, K=3)
module tb_cnn_pool_kxk;
    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int C  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] pxl_in;
    logic          mode;
    logic          stride2;
    logic [DW-1:0] pxl_out;
    logic          valid_out;
    logic          frame_done;

    cnn_pool_kxk #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CHANNEL_NUM_IN(C), .KERNEL(3)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .mode(mode),
        .stride2(stride2), .pxl_out(pxl_out), .valid_out(valid_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              mode;
        logic              stride;
        logic [1:0]        pat;
        logic [15:0]       val;
        logic [3:0]        n;
        logic [7:0][15:0]  exp;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_n_total = 0;
    int exp_val[$], exp_cyc[$], exp_done[$];
    int obs_val[$], obs_cyc[$], obs_done[$];
    vec_t vecs[8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out) begin
            obs_val.push_back(int'($signed(pxl_out)));
            obs_cyc.push_back(cyc);
        end
        if (frame_done) obs_done.push_back(cyc);
    end

    function automatic int rl(int x);
`ifdef CNN_POOL_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    function automatic vec_t mk(bit m, bit s, int pat, int val, int n,
                                int e0, int e1, int e2, int e3, int e4, int e5, int e6, int e7);
        vec_t v;
        v.mode = m; v.stride = s; v.pat = 2'(pat); v.val = 16'(val); v.n = 4'(n);
        v.exp[0] = 16'(e0); v.exp[1] = 16'(e1); v.exp[2] = 16'(e2); v.exp[3] = 16'(e3);
        v.exp[4] = 16'(e4); v.exp[5] = 16'(e5); v.exp[6] = 16'(e6); v.exp[7] = 16'(e7);
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_frame(vec_t v, bit gaps, bit toggle);
        int k = 0;
        int beat = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                for (int ch = 0; ch < C; ch++) begin
                    if (gaps) begin
                        repeat ($urandom_range(0, 2)) begin
                            valid_in = 1'b0;
                            pxl_in   = DW'($urandom);
                            @(negedge clk);
                        end
                    end
                    valid_in = 1'b1;
                    if (v.pat == 2'd0) pxl_in = v.val;
                    else pxl_in = (ch == 0) ? DW'(r * 4 + c) : DW'(-(r * 4 + c));
                    mode    = (toggle && beat > 0) ? ~v.mode : v.mode;
                    stride2 = (toggle && beat > 0) ? ~v.stride : v.stride;
                    if (r >= 2 && c >= 2 && (!v.stride || (((r - 2) % 2 == 0) && ((c - 2) % 2 == 0)))) begin
                        exp_val.push_back(rl(int'($signed(v.exp[k]))));
                        exp_cyc.push_back(cyc + 3);
                        k++;
                    end
                    if (r == H - 1 && c == W - 1 && ch == C - 1) exp_done.push_back(cyc + 3);
                    beat++;
                    @(negedge clk);
                end
            end
        end
        valid_in = 1'b0;
        exp_n_total += int'(v.n);
    endtask

    task automatic check_all(string tag);
        repeat (6) @(negedge clk);
        chk({tag, " out_count"}, obs_val.size(), exp_n_total);
        for (int i = 0; i < obs_val.size() && i < exp_val.size(); i++) begin
            chk($sformatf("%s out%0d value", tag, i), obs_val[i], exp_val[i]);
            chk($sformatf("%s out%0d cycle", tag, i), obs_cyc[i], exp_cyc[i]);
        end
        chk({tag, " done_count"}, obs_done.size(), exp_done.size());
        for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++) begin
            chk($sformatf("%s done%0d cycle", tag, i), obs_done[i], exp_done[i]);
        end
        exp_val.delete(); exp_cyc.delete(); exp_done.delete();
        obs_val.delete(); obs_cyc.delete(); obs_done.delete();
        exp_n_total = 0;
    endtask

    initial begin
        vecs[0] = mk(0, 0, 0, 90, 8, 90, 90, 90, 90, 90, 90, 90, 90);
        vecs[1] = mk(1, 0, 1, 0, 8, 10, 0, 11, -1, 14, -4, 15, -5);
        vecs[2] = mk(0, 1, 0, -18, 2, -18, -18, 0, 0, 0, 0, 0, 0);
        vecs[3] = mk(0, 0, 0, 32767, 8, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
        vecs[4] = mk(0, 0, 0, -32768, 8, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
        vecs[5] = mk(0, 0, 1, 0, 8, 5, -5, 6, -6, 9, -9, 10, -10);
        vecs[6] = mk(1, 1, 1, 0, 2, 10, 0, 0, 0, 0, 0, 0, 0);
        vecs[7] = mk(1, 0, 0, -32768, 8, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);

        reset = 1'b1; valid_in = 1'b0; pxl_in = '0; mode = 1'b0; stride2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset pxl_out", int'(pxl_out), 0);
        chk("reset valid_out", int'(valid_out), 0);
        chk("reset frame_done", int'(frame_done), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            drive_frame(vecs[t], 1'b0, 1'b0);
            check_all($sformatf("vec%0d", t));
        end

        drive_frame(vecs[1], 1'b1, 1'b1);
        check_all("gaps_toggle");

        drive_frame(vecs[0], 1'b0, 1'b0);
        drive_frame(vecs[2], 1'b0, 1'b0);
        drive_frame(vecs[1], 1'b0, 1'b0);
        check_all("back_to_back");

        // Abort a frame while the first two windows are still in flight
        for (int b = 0; b < 22; b++) begin
            valid_in = 1'b1; pxl_in = DW'(90); mode = 1'b0; stride2 = 1'b0;
            @(negedge clk);
        end
        valid_in = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("midreset no valid_out", obs_val.size(), 0);
        chk("midreset no frame_done", obs_done.size(), 0);
        obs_val.delete(); obs_cyc.delete(); obs_done.delete();

        drive_frame(vecs[5], 1'b0, 1'b0);
        drive_frame(vecs[1], 1'b0, 1'b0);
        drive_frame(vecs[6], 1'b0, 1'b0);
        check_all("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
